dff_rr_arbiter: RTL



---
 rtl/dff_rr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dff_rr_arbiter.sv
// dff_rr_arbiter: round-robin arbiter in front of one shared WIDTH-bit register.
// The winner's word is captured into dout and held valid until ack; one grant per word.
module dff_rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*WIDTH-1:0]     din,
  input  logic                   ack,
  output logic [N-1:0]           gnt,
  output logic [$clog2(N)-1:0]   owner,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic                   busy
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [N-1:0]     r_gnt;
  logic [N-1:0]     w_gnt_next;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    w_owner_next;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    w_last_next;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_dout_next;
  logic             r_valid;
  logic             w_valid_next;
  logic             r_busy;

  logic [2*N-1:0]   w_req2;
  logic [N-1:0]     w_rot;
  int unsigned      w_off;
  logic [IW-1:0]    w_win;
  logic [WIDTH-1:0] w_din_sel;

  // Winner: rotate req so bit 0 sits just past the last winner, take the lowest set bit.
  always_comb begin
    w_req2 = {req, req};
    w_rot  = N'(w_req2 >> (32'(r_last) + 32'd1));
    w_off  = 32'd0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = 32'(i);
    end
    w_win = IW'((32'(r_last) + w_off + 32'd1) % N);
  end

  // Select the winner's data word.
  always_comb begin
    w_din_sel = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_win == IW'(i)) w_din_sel = din[i*WIDTH +: WIDTH];
    end
  end

  // Next-state and next-output logic; grant is a single-cycle pulse.
  always_comb begin
    w_state_next = r_state;
    w_gnt_next   = '0;
    w_owner_next = r_owner;
    w_last_next  = r_last;
    w_dout_next  = r_dout;
    w_valid_next = r_valid;
    unique case (r_state)
      ST_IDLE: begin
        if (|req) begin
          w_state_next = ST_HOLD;
          w_gnt_next   = N'(1) << w_win;
          w_owner_next = w_win;
          w_last_next  = w_win;
          w_dout_next  = w_din_sel;
          w_valid_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (ack) begin
          w_state_next = ST_IDLE;
          w_valid_next = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 with top priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= IW'(N - 1);
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_gnt   <= w_gnt_next;
      r_owner <= w_owner_next;
      r_last  <= w_last_next;
      r_dout  <= w_dout_next;
      r_valid <= w_valid_next;
      r_busy  <= w_valid_next;
    end
  end

  assign gnt        = r_gnt;
  assign owner      = r_owner;
  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign busy       = r_busy;

endmodule
